// File: rtl/pipo_write_arbiter.sv
// Round-robin write arbiter for a parallel-in/parallel-out register bank.
// Grants one requester per clock and drives a one-hot write enable and shared write data.
module pipo_write_arbiter #(
   parameter int NUM_REQ        = 4,
   parameter int REGISTER_WIDTH = 16,
   parameter int NUM_REGS       = 8,
   parameter int ADDR_WIDTH     = 3
) (
   input  logic                               clk,
   input  logic                               rst,
   input  logic [NUM_REQ-1:0]                 req,
   input  logic [NUM_REQ*ADDR_WIDTH-1:0]      req_addr,
   input  logic [NUM_REQ*REGISTER_WIDTH-1:0]  req_data,
   output logic [NUM_REQ-1:0]                 ack,
   output logic [NUM_REGS-1:0]                reg_we,
   output logic [REGISTER_WIDTH-1:0]          reg_wdata,
   output logic                               addr_err,
   output logic                               busy,
   output logic                               state_dbg
);

   // Handshake: req[i] is a level held with stable addr/data until ack[i] pulses for one
   // cycle; the requester may drop req or present a new transaction from the next edge on.
   // A req still high during its own ack cycle is masked, so it is never granted twice.

   localparam int PTR_W = $clog2(NUM_REQ);
   localparam logic [PTR_W:0]   REQ_COUNT = (PTR_W+1)'(NUM_REQ);
   localparam logic [PTR_W-1:0] LAST_REQ  = PTR_W'(NUM_REQ - 1);

   typedef enum logic {
      IDLE  = 1'b0,
      GRANT = 1'b1
   } state_t;

   state_t                      state;
   logic [PTR_W-1:0]            ptr;
   logic [NUM_REQ-1:0]          eligible;
   logic [2*NUM_REQ-1:0]        elig_dbl;
   logic [NUM_REQ-1:0]          rotated;
   logic                        found;
   logic [PTR_W-1:0]            offset;
   logic [PTR_W:0]              sum;
   logic [PTR_W-1:0]            winner;
   logic [PTR_W-1:0]            ptr_next;
   logic [ADDR_WIDTH-1:0]       win_addr;
   logic [REGISTER_WIDTH-1:0]   win_data;
   logic                        addr_ok;
   logic [NUM_REGS-1:0]         we_onehot;

   assign eligible = req & ~ack;

   // Rotate so that bit 0 is the requester at ptr; the first set bit is the winner offset.
   assign elig_dbl = {eligible, eligible};
   assign rotated  = elig_dbl[ptr +: NUM_REQ];

   always_comb begin
      found  = 1'b0;
      offset = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         if (!found && rotated[k]) begin
            found  = 1'b1;
            offset = PTR_W'(k);
         end
      end
   end

   assign sum      = {1'b0, ptr} + {1'b0, offset};
   assign winner   = (sum >= REQ_COUNT) ? PTR_W'(sum - REQ_COUNT) : sum[PTR_W-1:0];
   assign ptr_next = (winner == LAST_REQ) ? '0 : winner + PTR_W'(1);

   assign win_addr  = req_addr[int'(winner)*ADDR_WIDTH +: ADDR_WIDTH];
   assign win_data  = req_data[int'(winner)*REGISTER_WIDTH +: REGISTER_WIDTH];
   assign addr_ok   = int'(win_addr) < NUM_REGS;
   assign we_onehot = NUM_REGS'(1) << win_addr;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= IDLE;
         ptr       <= '0;
         ack       <= '0;
         reg_we    <= '0;
         reg_wdata <= '0;
         addr_err  <= 1'b0;
      end else if (found) begin
         state     <= GRANT;
         ptr       <= ptr_next;
         ack       <= NUM_REQ'(1) << winner;
         reg_wdata <= win_data;
         // An out-of-range address still consumes the grant but never reaches the bank.
         if (addr_ok) begin
            reg_we   <= we_onehot;
            addr_err <= 1'b0;
         end else begin
            reg_we   <= '0;
            addr_err <= 1'b1;
         end
      end else begin
         state    <= IDLE;
         ack      <= '0;
         reg_we   <= '0;
         addr_err <= 1'b0;
      end
   end

   assign busy      = (|req) | (|ack);
   assign state_dbg = (state == GRANT);

endmodule
